// File: rtl/cordic_vectoring.sv
// ---------------------------------------------------------------------------
// cordic_vectoring
//
// Purpose:
//   Iterative CORDIC in vectoring mode. Converts a Cartesian vector (x_in,
//   y_in) in signed IQ 1.15 into a polar angle (atan2) in normalized turn
//   format (0x4000 = +90 deg, 0x8000 = +/-180 deg) and a magnitude. One
//   micro-rotation is performed per clock, 14 iterations in total, under a
//   start/busy/done handshake.
//
// Optional feature:
//   CORDIC_VEC_GAIN_COMP_EN - when defined, a COMP state multiplies the raw
//   CORDIC magnitude by 1/K (GAIN = 19898 / 2^15) so mag is the true
//   magnitude and latency is 16 cycles. When undefined, mag is the raw CORDIC
//   output (about 1.64676 x true magnitude) and latency is 15 cycles.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   conversion request, sampled only while idle
//   x_in   in   16  signed IQ 1.15 X component
//   y_in   in   16  signed IQ 1.15 Y component
//   busy   out  1   high while a conversion is in progress
//   done   out  1   one-cycle pulse, angle/mag valid
//   angle  out  16  atan2(y_in, x_in), two's complement turn format
//   mag    out  17  unsigned magnitude
// ---------------------------------------------------------------------------
module cordic_vectoring (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] x_in,
   input  logic [15:0] y_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] angle,
   output logic [16:0] mag
);

   localparam int N = 14;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      COMP,
      OUT
   } state_t;

   state_t             state;
   logic signed [17:0] x;
   logic signed [17:0] y;
   logic [15:0]        z;
   logic [3:0]         iter;
   logic               zero_vec;

   logic signed [17:0] x_ext;
   logic signed [17:0] y_ext;
   logic signed [17:0] pre_x;
   logic signed [17:0] pre_y;
   logic [15:0]        pre_z;
   logic signed [17:0] x_sh;
   logic signed [17:0] y_sh;
   logic [15:0]        atan_val;

`ifdef CORDIC_VEC_GAIN_COMP_EN
   localparam logic signed [15:0] GAIN = 16'sd19898;
   logic signed [33:0] prod;
   logic [16:0]        mag_c;
`endif

   // Pre-rotation into the right half-plane. Inputs are widened to 18 bits
   // first so that negating -32768 and the CORDIC growth of ~1.65x on a
   // full-scale diagonal both fit without wrapping. Left-half-plane vectors
   // are rotated by +/-90 degrees and the angle accumulator is seeded with
   // the matching quarter turn.
   always_comb begin
      x_ext = {{2{x_in[15]}}, x_in};
      y_ext = {{2{y_in[15]}}, y_in};
      pre_x = x_ext;
      pre_y = y_ext;
      pre_z = 16'h0000;
      if (x_ext[17]) begin
         if (!y_ext[17]) begin
            pre_x = y_ext;
            pre_y = -x_ext;
            pre_z = 16'h4000;
         end else begin
            pre_x = -y_ext;
            pre_y = x_ext;
            pre_z = 16'hC000;
         end
      end
   end

   // Arithmetic shifts for the current micro-rotation and the arctangent
   // table, atan(2^-i) scaled so that a full turn is 2^16.
   always_comb begin
      x_sh = x >>> iter;
      y_sh = y >>> iter;
      case (iter)
         4'd0:    atan_val = 16'd8192;
         4'd1:    atan_val = 16'd4836;
         4'd2:    atan_val = 16'd2555;
         4'd3:    atan_val = 16'd1297;
         4'd4:    atan_val = 16'd651;
         4'd5:    atan_val = 16'd326;
         4'd6:    atan_val = 16'd163;
         4'd7:    atan_val = 16'd81;
         4'd8:    atan_val = 16'd41;
         4'd9:    atan_val = 16'd20;
         4'd10:   atan_val = 16'd10;
         4'd11:   atan_val = 16'd5;
         4'd12:   atan_val = 16'd3;
         4'd13:   atan_val = 16'd1;
         default: atan_val = 16'd0;
      endcase
   end

`ifdef CORDIC_VEC_GAIN_COMP_EN
   // Gain compensation product; the true product of an 18-bit and a 16-bit
   // signed value always fits in 34 bits, so sizing both operands to 34 bits
   // loses nothing.
   always_comb begin
      prod = 34'(x) * 34'(GAIN);
   end
`endif

   // Control FSM and datapath. The zero-vector flag is captured at start
   // because the iterations never drive y negative for (0, 0), so z would
   // otherwise accumulate the whole atan table instead of reporting 0.
   // busy drops on the same edge that raises done, so a new start can be
   // accepted during the done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         x        <= '0;
         y        <= '0;
         z        <= '0;
         iter     <= '0;
         zero_vec <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         angle    <= '0;
         mag      <= '0;
`ifdef CORDIC_VEC_GAIN_COMP_EN
         mag_c    <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  x        <= pre_x;
                  y        <= pre_y;
                  z        <= pre_z;
                  iter     <= '0;
                  zero_vec <= (x_in == 16'h0000) && (y_in == 16'h0000);
                  busy     <= 1'b1;
                  state    <= ITER;
               end
            end
            ITER: begin
               if (!y[17]) begin
                  x <= x + y_sh;
                  y <= y - x_sh;
                  z <= z + atan_val;
               end else begin
                  x <= x - y_sh;
                  y <= y + x_sh;
                  z <= z - atan_val;
               end
               if (iter == 4'(N - 1)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                  state <= COMP;
`else
                  state <= OUT;
`endif
               end else begin
                  iter <= iter + 4'd1;
               end
            end
            COMP: begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
               mag_c <= prod[31:15];
               state <= OUT;
`else
               state <= IDLE;
`endif
            end
            OUT: begin
               angle <= zero_vec ? 16'h0000 : z;
`ifdef CORDIC_VEC_GAIN_COMP_EN
               mag   <= mag_c;
`else
               mag   <= x[16:0];
`endif
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vectoring.sv
// ---------------------------------------------------------------------------
// tb_cordic_vectoring
//
// Purpose:
//   Directed self-checking bench for cordic_vectoring. Drives hand-picked
//   vectors (axes, diagonal, left half-plane, full-scale negative corner,
//   zero), the start/busy/done handshake (ignored start while busy,
//   back-to-back start in the done cycle) and an asynchronous reset in the
//   middle of a conversion. Expected angles and magnitudes are worked out by
//   hand with small tolerances for CORDIC truncation error.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_cordic_vectoring;

`ifdef CORDIC_VEC_GAIN_COMP_EN
   localparam int LAT      = 16;
   localparam int MAG_AXIS = 16384;
   localparam int TOL_AXIS = 4;
   localparam int MAG_DIAG = 23170;
   localparam int TOL_DIAG = 6;
   localparam int MAG_EXT  = 46341;
   localparam int TOL_EXT  = 10;
`else
   localparam int LAT      = 15;
   localparam int MAG_AXIS = 26981;
   localparam int TOL_AXIS = 8;
   localparam int MAG_DIAG = 38155;
   localparam int TOL_DIAG = 16;
   localparam int MAG_EXT  = 76315;
   localparam int TOL_EXT  = 24;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] x_in;
   logic [15:0] y_in;
   logic        busy;
   logic        done;
   logic [15:0] angle;
   logic [16:0] mag;

   int checks;
   int failures;
   int edges;
   int n_done;

   cordic_vectoring dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .x_in  (x_in),
      .y_in  (y_in),
      .busy  (busy),
      .done  (done),
      .angle (angle),
      .mag   (mag)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Presents a vector with start high so the DUT samples it on the next
   // rising edge (edge k), then drops start 1 ns after that edge.
   task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv);
      x_in  = xv;
      y_in  = yv;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts rising edges after edge k until done is seen 1 ns after an edge.
   // Returns -1 if done does not appear within the cycle budget.
   task automatic waitDone(input int startEdges, output int count);
      bit found;
      found = 1'b0;
      count = startEdges;
      while (!found && count < startEdges + 40) begin
         @(posedge clk);
         #1;
         count++;
         if (done) found = 1'b1;
      end
      if (!found) count = -1;
   endtask

   // Counts done pulses over a fixed window of cycles.
   task automatic countDones(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (done) n++;
      end
   endtask

   // Compares an observed value against an expected value within +/-tol.
   // With wrap16 set, the difference is taken modulo 2^16 so angles close to
   // +/-180 degrees compare correctly.
   task automatic checkOutput(input string tag, input int observed,
                              input int expected, input int tol,
                              input bit wrap16);
      int diff;
      bit ok;
      diff = observed - expected;
      if (wrap16) diff = int'($signed(16'(diff)));
      ok = (diff <= tol) && (diff >= -tol);
      checks++;
      assert (ok === 1'b1)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d (tol %0d)",
                tag, observed, expected, tol);
      end
   endtask

   // Directed sequence
   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      x_in     = 16'h0000;
      y_in     = 16'h0000;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy",  int'(busy),  0, 0, 1'b0);
      checkOutput("reset_done",  int'(done),  0, 0, 1'b0);
      checkOutput("reset_angle", int'(angle), 0, 0, 1'b0);
      checkOutput("reset_mag",   int'(mag),   0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] positive X axis");
      applyStimulus(16'd16384, 16'd0);
      checkOutput("axis_busy", int'(busy), 1, 0, 1'b0);
      waitDone(0, edges);
      checkOutput("axis_latency", edges, LAT, 0, 1'b0);
      checkOutput("axis_angle", int'(angle), 16'h0000, 2, 1'b1);
      checkOutput("axis_mag", int'(mag), MAG_AXIS, TOL_AXIS, 1'b0);

      $display("[TB] positive Y axis");
      applyStimulus(16'd0, 16'd16384);
      waitDone(0, edges);
      checkOutput("yaxis_angle", int'(angle), 16'h4000, 2, 1'b1);

      $display("[TB] diagonal");
      applyStimulus(16'd16384, 16'd16384);
      waitDone(0, edges);
      checkOutput("diag_angle", int'(angle), 16'h2000, 2, 1'b1);
      checkOutput("diag_mag", int'(mag), MAG_DIAG, TOL_DIAG, 1'b0);

      $display("[TB] negative X axis");
      applyStimulus(16'hC000, 16'd0);
      waitDone(0, edges);
      checkOutput("negx_angle", int'(angle), 16'h8000, 2, 1'b1);

      $display("[TB] full-scale negative corner");
      applyStimulus(16'h8000, 16'h8000);
      waitDone(0, edges);
      checkOutput("corner_angle", int'(angle), 16'hA000, 2, 1'b1);
      checkOutput("corner_mag", int'(mag), MAG_EXT, TOL_EXT, 1'b0);

      $display("[TB] start while busy is ignored");
      applyStimulus(16'd16384, 16'd0);
      repeat (3) @(posedge clk);
      #1;
      x_in  = 16'd0;
      y_in  = 16'd16384;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(4, edges);
      checkOutput("ignore_latency", edges, LAT, 0, 1'b0);
      checkOutput("ignore_angle", int'(angle), 16'h0000, 2, 1'b1);
      countDones(20, n_done);
      checkOutput("ignore_extra_done", n_done, 0, 0, 1'b0);

      $display("[TB] back-to-back start in done cycle");
      applyStimulus(16'd16384, 16'd16384);
      waitDone(0, edges);
      checkOutput("b2b_busy_in_done", int'(busy), 0, 0, 1'b0);
      applyStimulus(16'hC000, 16'd0);
      waitDone(0, edges);
      checkOutput("b2b_latency", edges, LAT, 0, 1'b0);
      checkOutput("b2b_angle", int'(angle), 16'h8000, 2, 1'b1);

      $display("[TB] reset mid-conversion");
      applyStimulus(16'd16384, 16'd0);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy",  int'(busy),  0, 0, 1'b0);
      checkOutput("abort_done",  int'(done),  0, 0, 1'b0);
      checkOutput("abort_angle", int'(angle), 0, 0, 1'b0);
      checkOutput("abort_mag",   int'(mag),   0, 0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      countDones(25, n_done);
      checkOutput("abort_no_done", n_done, 0, 0, 1'b0);
      applyStimulus(16'h8000, 16'h8000);
      waitDone(0, edges);
      checkOutput("after_reset_latency", edges, LAT, 0, 1'b0);
      checkOutput("after_reset_angle", int'(angle), 16'hA000, 2, 1'b1);

      $display("[TB] zero vector");
      applyStimulus(16'd0, 16'd0);
      waitDone(0, edges);
      checkOutput("zero_latency", edges, LAT, 0, 1'b0);
      checkOutput("zero_angle", int'(angle), 0, 0, 1'b0);
      checkOutput("zero_mag", int'(mag), 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, failures);
      $finish;
   end

endmodule
